// File: rtl/regfile_pkg.sv
// ============================================================================
//  regfile_pkg : shared constants and popcount helper for the regfile_mp slice
//  Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int c_DEFAULT_DATA_W = 32;
   localparam int c_DEFAULT_ADDR_W = 5;
   localparam int c_ZERO_IDX       = 0;

   // Widest busy vector the helper accepts; covers ADDR_W up to 10.
   localparam int c_MAX_DEPTH      = 1024;

   function automatic int popcount(input logic [c_MAX_DEPTH-1:0] v);
      int n;
      n = 0;
      for (int k = 0; k < c_MAX_DEPTH; k++) begin
         n += v[k] ? 1 : 0;
      end
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  regfile_scoreboard : per-register pending-write bits, pending count and
//  per-read-port busy lookup.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = c_DEFAULT_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     flush,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        rd_busy,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int c_DEPTH = 2**ADDR_W;

   logic [c_DEPTH-1:0]     r_busy;
   logic [c_DEPTH-1:0]     w_busy_nxt;
   logic [c_MAX_DEPTH-1:0] w_busy_ext;
   logic [ADDR_W:0]        r_pend_cnt;

   // Clear from writeback first, so a same-edge issue to that register wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (wr_en) begin
         w_busy_nxt[wr_addr] = 1'b0;
      end
      if (flush) begin
         w_busy_nxt = '0;
      end else if (sb_set) begin
         w_busy_nxt[sb_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         w_busy_nxt[c_ZERO_IDX] = 1'b0;
      end
   end

   always_comb begin
      w_busy_ext              = '0;
      w_busy_ext[c_DEPTH-1:0] = w_busy_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= '0;
         r_pend_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_pend_cnt <= (ADDR_W+1)'(popcount(w_busy_ext));
      end
   end

   assign pend_cnt = r_pend_cnt;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
      assign rd_busy[i] = r_busy[rd_addr[i*ADDR_W +: ADDR_W]];
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  regfile_mp : multi-read-port register file with pending-write scoreboard.
//  Optional write-to-read forwarding under `REGFILE_BYPASS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = c_DEFAULT_DATA_W,
   parameter int ADDR_W   = c_DEFAULT_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   input  logic                     flush,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int c_DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [c_DEPTH];
   logic [NUM_RD-1:0] w_sb_busy;
   logic              w_wr_ok;

   assign w_wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(c_ZERO_IDX)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < c_DEPTH; k++) begin
            r_mem[k] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr),
      .flush    (flush),
      .rd_addr  (rd_addr),
      .rd_busy  (w_sb_busy),
      .pend_cnt (pend_cnt)
   );

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_is_zero;
      logic [DATA_W-1:0] w_data;
      logic              w_busy;

      assign w_addr    = rd_addr[i*ADDR_W +: ADDR_W];
      assign w_is_zero = (ZERO_REG != 0) && (w_addr == ADDR_W'(c_ZERO_IDX));

`ifdef REGFILE_BYPASS_EN
      // A colliding writeback is forwarded; busy then follows what the edge will leave.
      logic w_hit;
      assign w_hit  = wr_en && (wr_addr == w_addr) && !w_is_zero;
      assign w_data = w_hit ? wr_data : r_mem[w_addr];
      assign w_busy = w_hit ? (sb_set && !flush && (sb_addr == w_addr)) : w_sb_busy[i];
`else
      assign w_data = r_mem[w_addr];
      assign w_busy = w_sb_busy[i];
`endif

      assign rd_data[i*DATA_W +: DATA_W] = w_is_zero ? '0 : w_data;
      assign rd_busy[i]                  = w_busy && !w_is_zero;
   end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  tb_regfile_mp : directed self-checking bench for regfile_mp (2 ports).
//  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data;
   logic [NR-1:0]     rd_busy;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic              sb_set;
   logic [AW-1:0]     sb_addr;
   logic              flush;
   logic [AW:0]       pend_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   regfile_mp #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_RD   (NR),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .sb_set   (sb_set),
      .sb_addr  (sb_addr),
      .flush    (flush),
      .pend_cnt (pend_cnt)
   );

   task automatic idle();
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      sb_set  = 1'b0;
      sb_addr = '0;
      flush   = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      rd(5'd0, 5'd31);
      step();
      step();
      #1;
      checks++;
      if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp %h", rd_data, 64'd0); end
      checks++;
      if (rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp %b", rd_busy, 2'b00); end
      checks++;
      if (pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_pend got %0d exp %0d", pend_cnt, 0); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset_midstream();
      wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'd9;
      sb_set = 1'b1; sb_addr = 5'd9;
      step();
      wr_addr = 5'd9; wr_data = 32'd4;
      sb_addr = 5'd11;
      step();
      idle();
      rd(5'd8, 5'd9);
      #1;
      checks++;
      if (rd_data !== {32'd4, 32'd9}) begin errors++; $display("FAIL mid_pre_data got %h exp %h", rd_data, {32'd4, 32'd9}); end
      checks++;
      if (pend_cnt !== 6'd1) begin errors++; $display("FAIL mid_pre_pend got %0d exp %0d", pend_cnt, 1); end
      // Assert reset between edges with a write pending; it must act immediately.
      wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h55;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rd_data !== 64'd0) begin errors++; $display("FAIL mid_rst_data got %h exp %h", rd_data, 64'd0); end
      checks++;
      if (pend_cnt !== 6'd0) begin errors++; $display("FAIL mid_rst_pend got %0d exp %0d", pend_cnt, 0); end
      rd(5'd11, 5'd11);
      #1;
      checks++;
      if (rd_busy !== 2'b00) begin errors++; $display("FAIL mid_rst_busy got %b exp %b", rd_busy, 2'b00); end
      step();
      rd(5'd8, 5'd9);
      #1;
      checks++;
      if (rd_data !== 64'd0) begin errors++; $display("FAIL mid_rst_discard got %h exp %h", rd_data, 64'd0); end
      idle();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sb_basic();
      sb_set = 1'b1; sb_addr = 5'd10;
      step();
      idle();
      rd(5'd10, 5'd10);
      #1;
      checks++;
      if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_busy got %b exp %b", rd_busy, 2'b11); end
      checks++;
      if (pend_cnt !== 6'd1) begin errors++; $display("FAIL sb_pend got %0d exp %0d", pend_cnt, 1); end
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd5;
      #1;
`ifdef REGFILE_BYPASS_EN
      checks++;
      if (rd_data !== {32'd5, 32'd5}) begin errors++; $display("FAIL sb_wr_comb_data got %h exp %h", rd_data, {32'd5, 32'd5}); end
      checks++;
      if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_wr_comb_busy got %b exp %b", rd_busy, 2'b00); end
`else
      checks++;
      if (rd_data !== 64'd0) begin errors++; $display("FAIL sb_wr_comb_data got %h exp %h", rd_data, 64'd0); end
      checks++;
      if (rd_busy !== 2'b11) begin errors++; $display("FAIL sb_wr_comb_busy got %b exp %b", rd_busy, 2'b11); end
`endif
      step();
      idle();
      #1;
      checks++;
      if (rd_data !== {32'd5, 32'd5}) begin errors++; $display("FAIL sb_wr_data got %h exp %h", rd_data, {32'd5, 32'd5}); end
      checks++;
      if (rd_busy !== 2'b00) begin errors++; $display("FAIL sb_wr_busy got %b exp %b", rd_busy, 2'b00); end
      checks++;
      if (pend_cnt !== 6'd0) begin errors++; $display("FAIL sb_wr_pend got %0d exp %0d", pend_cnt, 0); end
   endtask

   task automatic test_same_edge();
      sb_set = 1'b1; sb_addr = 5'd12;
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'd6;
      step();
      idle();
      rd(5'd12, 5'd12);
      #1;
      checks++;
      if (rd_data !== {32'd6, 32'd6}) begin errors++; $display("FAIL same_data got %h exp %h", rd_data, {32'd6, 32'd6}); end
      checks++;
      if (rd_busy !== 2'b11) begin errors++; $display("FAIL same_busy got %b exp %b", rd_busy, 2'b11); end
      checks++;
      if (pend_cnt !== 6'd1) begin errors++; $display("FAIL same_pend got %0d exp %0d", pend_cnt, 1); end
   endtask

   task automatic test_flush();
      logic [AW-1:0] regs [3];
      regs[0] = 5'd8; regs[1] = 5'd9; regs[2] = 5'd15;
      for (int k = 0; k < 3; k++) begin
         sb_set = 1'b1; sb_addr = regs[k];
         step();
      end
      idle();
      #1;
      checks++;
      if (pend_cnt !== 6'd4) begin errors++; $display("FAIL flush_pre_pend got %0d exp %0d", pend_cnt, 4); end
      flush = 1'b1;
      sb_set = 1'b1; sb_addr = 5'd24;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd7;
      step();
      idle();
      rd(5'd24, 5'd9);
      #1;
      checks++;
      if (pend_cnt !== 6'd0) begin errors++; $display("FAIL flush_pend got %0d exp %0d", pend_cnt, 0); end
      checks++;
      if (rd_busy !== 2'b00) begin errors++; $display("FAIL flush_busy got %b exp %b", rd_busy, 2'b00); end
      checks++;
      if (rd_data !== {32'd7, 32'd0}) begin errors++; $display("FAIL flush_data got %h exp %h", rd_data, {32'd7, 32'd0}); end
   endtask

   task automatic test_zero_reg();
      sb_set = 1'b1; sb_addr = 5'd3;
      step();
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
      sb_set = 1'b1; sb_addr = 5'd0;
      rd(5'd0, 5'd0);
      #1;
      checks++;
      if (rd_data !== 64'd0) begin errors++; $display("FAIL zero_comb_data got %h exp %h", rd_data, 64'd0); end
      step();
      idle();
      rd(5'd0, 5'd3);
      #1;
      checks++;
      if (rd_data[DW-1:0] !== 32'd0) begin errors++; $display("FAIL zero_data got %h exp %h", rd_data[DW-1:0], 32'd0); end
      checks++;
      if (rd_busy !== 2'b10) begin errors++; $display("FAIL zero_busy got %b exp %b", rd_busy, 2'b10); end
      checks++;
      if (pend_cnt !== 6'd1) begin errors++; $display("FAIL zero_pend got %0d exp %0d", pend_cnt, 1); end
   endtask

   task automatic test_bypass();
      wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'd3;
      step();
      rd(5'd25, 5'd26);
      wr_data = 32'd8;
      #1;
`ifdef REGFILE_BYPASS_EN
      checks++;
      if (rd_data !== {32'd0, 32'd8}) begin errors++; $display("FAIL byp_data got %h exp %h", rd_data, {32'd0, 32'd8}); end
`else
      checks++;
      if (rd_data !== {32'd0, 32'd3}) begin errors++; $display("FAIL byp_data got %h exp %h", rd_data, {32'd0, 32'd3}); end
`endif
      step();
      wr_data = 32'd9;
      sb_set = 1'b1; sb_addr = 5'd25;
      #1;
`ifdef REGFILE_BYPASS_EN
      checks++;
      if (rd_data[DW-1:0] !== 32'd9 || rd_busy[0] !== 1'b1) begin errors++; $display("FAIL byp_set got data=%h busy=%b exp data=%h busy=1", rd_data[DW-1:0], rd_busy[0], 32'd9); end
`else
      checks++;
      if (rd_data[DW-1:0] !== 32'd8 || rd_busy[0] !== 1'b0) begin errors++; $display("FAIL byp_set got data=%h busy=%b exp data=%h busy=0", rd_data[DW-1:0], rd_busy[0], 32'd8); end
`endif
      step();
      idle();
      #1;
      checks++;
      if (rd_data[DW-1:0] !== 32'd9 || rd_busy !== 2'b01) begin errors++; $display("FAIL byp_after got data=%h busy=%b exp data=%h busy=01", rd_data[DW-1:0], rd_busy, 32'd9); end
      checks++;
      if (pend_cnt !== 6'd2) begin errors++; $display("FAIL byp_pend got %0d exp %0d", pend_cnt, 2); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals [4];
      vals[0] = 32'd11; vals[1] = 32'd22; vals[2] = 32'd33; vals[3] = 32'd44;
      for (int k = 0; k < 4; k++) begin
         wr_en = 1'b1; wr_addr = AW'(k + 1); wr_data = vals[k];
         step();
      end
      idle();
      flush = 1'b1;
      step();
      idle();
      rd(5'd1, 5'd2);
      #1;
      checks++;
      if (rd_data !== {32'd22, 32'd11}) begin errors++; $display("FAIL b2b_12 got %h exp %h", rd_data, {32'd22, 32'd11}); end
      rd(5'd3, 5'd4);
      #1;
      checks++;
      if (rd_data !== {32'd44, 32'd33}) begin errors++; $display("FAIL b2b_34 got %h exp %h", rd_data, {32'd44, 32'd33}); end
      checks++;
      if (pend_cnt !== 6'd0) begin errors++; $display("FAIL b2b_flush_pend got %0d exp %0d", pend_cnt, 0); end
   endtask

   initial begin
      rd_addr = '0;
      test_reset();
      test_reset_midstream();
      test_sb_basic();
      test_same_edge();
      test_flush();
      test_zero_reg();
      test_bypass();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with a pending-write scoreboard, the successor to the single-pair register file in the pipelined MIPS datapath. It sits between decode and writeback:
- Decode reads `NUM_RD` source operands and learns whether each one still has an in-flight producer.
- Decode marks its destination register as pending.
- Writeback commits results and clears the pending mark.
- A flush clears all pending marks on a pipeline squash.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth is `2**ADDR_W`
- `NUM_RD`, 2, number of independent read ports (1..4)
- `ZERO_REG`, 1, when 1 register 0 reads 0, ignores writes and is never busy

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `rd_addr`  in  `NUM_RD*ADDR_W`  read addresses; port i uses slice i
- `rd_data`  out  `NUM_RD*DATA_W`  read data, combinational from `rd_addr`
- `rd_busy`  out  `NUM_RD`  port i source has a pending write
- `wr_en`  in  1  writeback commit strobe
- `wr_addr`  in  `ADDR_W`  writeback destination
- `wr_data`  in  `DATA_W`  writeback value
- `sb_set`  in  1  mark `sb_addr` pending (destination issue)
- `sb_addr`  in  `ADDR_W`  register to mark pending
- `flush`  in  1  clear all pending marks
- `pend_cnt`  out  `ADDR_W+1`  number of registers currently pending (registered)

## Operation
- Reset (`rst_n`=0, asynchronous): all registers 0, all busy bits 0, `pend_cnt`=0. `rd_data` then reads 0 for every address; `rd_busy`=0.
- Reset asserted mid-operation discards any write or set of that cycle. First capture occurs on the first rising edge after `rst_n` rises.
- Read: `rd_data[i]` = `mem[rd_addr[i]]`. `rd_busy[i]` = `busy[rd_addr[i]]`. No read enable.
- Write: on a rising edge with `wr_en`=1, `mem[wr_addr]` <= `wr_data` and `busy[wr_addr]` <= 0. A write to a non-busy register is legal.
- Scoreboard set: on a rising edge with `sb_set`=1 and `flush`=0, `busy[sb_addr]` <= 1.
- Same-cycle `sb_set` and `wr_en` to the same address: data is written and busy ends at 1. A new producer overrides the old clear.
- Flush: on a rising edge with `flush`=1, all busy bits <= 0 and `sb_set` is ignored. `wr_en` still commits data.
- `ZERO_REG`=1, address 0:
  - writes dropped
  - `sb_set` dropped
  - `rd_data`=0 and `rd_busy`=0 regardless of state
- `pend_cnt`: registered popcount of the next busy vector, so it is always consistent with busy bits in the same cycle. Range 0..`2**ADDR_W`, hence `ADDR_W+1` bits.

## Timing
- Read latency 0 cycles (combinational). Write and scoreboard latency: visible after 1 rising edge.
- With bypass compiled out, a read in the same cycle as a write to that address returns the old value and old busy.
- All ports are independent. Any number of read ports may share one address.

## Configuration
- `REGFILE_BYPASS_EN` defined: write-to-read forwarding is enabled. For each port i, when `wr_en`=1, `wr_addr`==`rd_addr[i]` and the address is not the zero register:
  - `rd_data[i]`=`wr_data`
  - `rd_busy[i]`=0, unless `sb_set` targets the same address with `flush`=0, in which case `rd_busy[i]`=1
- `REGFILE_BYPASS_EN` undefined: no forwarding; the pipeline must stall one cycle on a writeback-to-read collision.

## Structure
- Package `regfile_pkg` holds:
  - default `DATA_W`/`ADDR_W` localparams
  - the zero-register index constant
  - a popcount function used for `pend_cnt`
- Sub-module `regfile_scoreboard` contains:
  - the busy vector, with set/clear/flush priority
  - `pend_cnt`
  - per-port busy lookup
- The top module holds the data array, the read muxes and the optional bypass.

## Test plan
- Reset with `rst_n`=0 mid-stream after writes to r8=9 and r9=4 -> all `rd_data`=0, `rd_busy`=0, `pend_cnt`=0 immediately, without waiting for an edge.
- `sb_set` r10, next cycle read r10 on both ports -> `rd_busy`=2'b11, `pend_cnt`=1; then `wr_en` r10=5 -> after edge `rd_data`=5, `rd_busy`=0, `pend_cnt`=0.
- Same edge: `sb_set` r12 and `wr_en` r12=6 -> r12 reads 6, busy stays 1, `pend_cnt`=1.
- Set r8, r9, r15 then `flush` together with `sb_set` r24 and `wr_en` r9=7 -> `pend_cnt`=0, r24 not busy, r9 reads 7.
- `wr_en` r0=0xFFFF_FFFF plus `sb_set` r0 -> r0 reads 0, `rd_busy`=0, `pend_cnt` unchanged.
- Read r25 while writing r25=8 in the same cycle -> with `REGFILE_BYPASS_EN`, `rd_data`=8 combinationally; without it, old value until after the edge.
